// File: rtl/mux_8x1_scan.sv
// Round-robin 8:1 bit multiplexer with valid/ready output and per-channel ack pulses.
// Grants one requester per word: IDLE -> HOLD (word held) -> ACK (one-cycle ack) -> IDLE.

module mux_8x1_scan #(
    parameter int unsigned FIRST_CH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic in4,
    input  logic in5,
    input  logic in6,
    input  logic in7,
    input  logic in8,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    input  logic req4,
    input  logic req5,
    input  logic req6,
    input  logic req7,
    input  logic req8,
    input  logic out_ready,
    output logic out_y,
    output logic outs1,
    output logic outs2,
    output logic outs3,
    output logic out_valid,
    output logic ack1,
    output logic ack2,
    output logic ack3,
    output logic ack4,
    output logic ack5,
    output logic ack6,
    output logic ack7,
    output logic ack8
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHold = 2'd1;
    localparam logic [1:0] StAck  = 2'd2;

    localparam logic [2:0] FirstPtr = 3'(FIRST_CH);

    logic [7:0] in_vec;
    logic [7:0] req_vec;

    logic [1:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic       y_q, y_d;
    logic       valid_q, valid_d;
    logic [7:0] ack_q, ack_d;

    logic       gnt_found;
    logic [2:0] gnt_idx;

    assign in_vec  = {in8, in7, in6, in5, in4, in3, in2, in1};
    assign req_vec = {req8, req7, req6, req5, req4, req3, req2, req1};

    // Search upward from the pointer, wrapping 7->0; first hit wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!gnt_found && req_vec[ptr_q + 3'(i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ptr_q + 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        y_d     = y_q;
        valid_d = valid_q;
        ack_d   = '0;
        case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    y_d     = in_vec[gnt_idx];
                    sel_d   = gnt_idx;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                // Word and select are frozen here; only out_ready matters.
                if (out_ready) begin
                    valid_d       = 1'b0;
                    ptr_d         = sel_q + 3'd1;
                    ack_d[sel_q]  = 1'b1;
                    state_d       = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= FirstPtr;
            sel_q   <= 3'd0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    // outs1 is the MSB so the index drives a 1x8 demux select directly.
    assign outs1     = sel_q[2];
    assign outs2     = sel_q[1];
    assign outs3     = sel_q[0];
    assign out_y     = y_q;
    assign out_valid = valid_q;

    assign ack1 = ack_q[0];
    assign ack2 = ack_q[1];
    assign ack3 = ack_q[2];
    assign ack4 = ack_q[3];
    assign ack5 = ack_q[4];
    assign ack6 = ack_q[5];
    assign ack7 = ack_q[6];
    assign ack8 = ack_q[7];

endmodule

// File: tb/tb_mux_8x1_scan.sv
// Scoreboard bench for mux_8x1_scan: expected words queued at stimulus time,
// popped and compared by a monitor whenever a word transfers.

module tb_mux_8x1_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_v = 8'h00;
    logic [7:0] req_v = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_y, outs1, outs2, outs3, out_valid;
    logic       ack1, ack2, ack3, ack4, ack5, ack6, ack7, ack8;

    logic [7:0] ack_v;
    logic [2:0] sel;
    logic [7:0] demux;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] sb[$];   // {channel, data bit}
    logic       ack_due = 1'b0;
    logic [2:0] ack_ch = 3'd0;

    always #5 clk = ~clk;

    mux_8x1_scan #(.FIRST_CH(0)) dut (
        .clk(clk), .rst(rst),
        .in1(in_v[0]), .in2(in_v[1]), .in3(in_v[2]), .in4(in_v[3]),
        .in5(in_v[4]), .in6(in_v[5]), .in7(in_v[6]), .in8(in_v[7]),
        .req1(req_v[0]), .req2(req_v[1]), .req3(req_v[2]), .req4(req_v[3]),
        .req5(req_v[4]), .req6(req_v[5]), .req7(req_v[6]), .req8(req_v[7]),
        .out_ready(out_ready), .out_y(out_y),
        .outs1(outs1), .outs2(outs2), .outs3(outs3), .out_valid(out_valid),
        .ack1(ack1), .ack2(ack2), .ack3(ack3), .ack4(ack4),
        .ack5(ack5), .ack6(ack6), .ack7(ack7), .ack8(ack8)
    );

    assign ack_v = {ack8, ack7, ack6, ack5, ack4, ack3, ack2, ack1};
    assign sel   = {outs1, outs2, outs3};

    // Downstream 1x8 demux fed by the mux outputs.
    always_comb begin
        demux      = 8'h00;
        demux[sel] = out_y;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!out_valid && cyc < budget);
        check_eq("valid_seen", 32'(out_valid), 1);
    endtask

    // Monitor: word transfer on HOLD with out_ready, ack exactly one cycle later.
    always @(negedge clk) begin
        logic [7:0] exp_ack;
        logic [3:0] exp_w;
        if (rst) begin
            ack_due = 1'b0;
        end else begin
            exp_ack = ack_due ? (8'h01 << ack_ch) : 8'h00;
            check_eq("ack_pulse", 32'(ack_v), 32'(exp_ack));
            check_eq("ack_while_valid", 32'((|ack_v) & out_valid), 0);
            ack_due = 1'b0;
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_w = sb.pop_front();
                    check_eq("word", 32'({sel, out_y}), 32'(exp_w));
                    check_eq("demux", 32'(demux), 32'(8'(exp_w[0]) << exp_w[3:1]));
                    ack_due = 1'b1;
                    ack_ch  = exp_w[3:1];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check_eq("rst_valid", 32'(out_valid), 0);
        check_eq("rst_y", 32'(out_y), 0);
        check_eq("rst_outs", 32'(sel), 0);
        check_eq("rst_ack", 32'(ack_v), 0);

        // Single request on channel 2, granted on the first edge out of reset
        rst = 1'b0;
        req_v = 8'b0000_0100;
        in_v  = 8'b0000_0100;
        out_ready = 1'b1;
        sb.push_back({3'd2, 1'b1});
        step();
        check_eq("single_valid", 32'(out_valid), 1);
        check_eq("single_y", 32'(out_y), 1);
        check_eq("single_outs", 32'(sel), 3'b010);
        step();
        check_eq("single_ack", 32'(ack_v), 8'b0000_0100);
        check_eq("single_valid_clr", 32'(out_valid), 0);
        req_v = 8'h00;
        step();
        check_eq("single_idle_ack", 32'(ack_v), 0);
        check_eq("single_idle_valid", 32'(out_valid), 0);
        step();
        check_eq("idle_no_req", 32'(out_valid), 0);

        // Round robin over all eight channels from pointer 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_v = 8'hFF;
        in_v  = 8'hAA;
        for (int w = 0; w < 9; w++) sb.push_back({3'(w % 8), 1'(w % 2)});
        for (int w = 0; w < 9; w++) begin
            wait_valid(6, cyc);
            check_eq("rr_outs", 32'(sel), 32'(w % 8));
            check_eq("rr_y", 32'(out_y), 32'(w % 2));
            check_eq("rr_spacing", 32'(cyc), (w == 0) ? 1 : 3);
            if (w == 8) req_v = 8'h00;
        end
        step();
        step();

        // Backpressure on channel 5 while its data toggles and req drops
        out_ready = 1'b0;
        req_v = 8'b0010_0000;
        in_v  = 8'b0010_0000;
        sb.push_back({3'd5, 1'b1});
        wait_valid(3, cyc);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_valid", 32'(out_valid), 1);
            check_eq("bp_y", 32'(out_y), 1);
            check_eq("bp_outs", 32'(sel), 3'b101);
            check_eq("bp_no_ack", 32'(ack_v), 0);
            in_v[5]  = ~in_v[5];
            req_v[5] = 1'b0;
            step();
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_ack", 32'(ack_v), 8'b0010_0000);
        step();
        check_eq("bp_ack_once", 32'(ack_v), 0);

        // Wrap priority: serve channel 6, then channels 0 and 7 contend
        req_v = 8'b0100_0000;
        in_v  = 8'h00;
        sb.push_back({3'd6, 1'b0});
        wait_valid(3, cyc);
        check_eq("wrap_pre_outs", 32'(sel), 3'd6);
        step();
        req_v = 8'b1000_0001;
        in_v  = 8'b1000_0001;
        sb.push_back({3'd7, 1'b1});
        sb.push_back({3'd0, 1'b1});
        step();
        check_eq("no_grant_in_ack", 32'(out_valid), 0);
        wait_valid(3, cyc);
        check_eq("wrap_first", 32'(sel), 3'd7);
        step();
        req_v[7] = 1'b0;
        wait_valid(4, cyc);
        check_eq("wrap_second", 32'(sel), 3'd0);
        step();
        req_v = 8'h00;
        step();

        // Reset during HOLD of channel 2 abandons the word
        out_ready = 1'b0;
        req_v = 8'b0000_0100;
        in_v  = 8'b0000_0100;
        wait_valid(3, cyc);
        check_eq("mid_outs", 32'(sel), 3'd2);
        rst = 1'b1;
        step();
        check_eq("mid_rst_valid", 32'(out_valid), 0);
        check_eq("mid_rst_y", 32'(out_y), 0);
        check_eq("mid_rst_outs", 32'(sel), 0);
        check_eq("mid_rst_ack", 32'(ack_v), 0);
        rst = 1'b0;
        req_v = 8'b0000_0101;
        in_v  = 8'b0000_0001;
        out_ready = 1'b1;
        sb.push_back({3'd0, 1'b1});
        sb.push_back({3'd2, 1'b0});
        wait_valid(3, cyc);
        check_eq("post_rst_first", 32'(sel), 3'd0);
        step();
        req_v[0] = 1'b0;
        wait_valid(4, cyc);
        check_eq("post_rst_second", 32'(sel), 3'd2);
        step();
        req_v = 8'h00;
        step();
        step();

        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_8x1_scan.md
MUX_8X1_SCAN -- requirements
Module: mux_8x1_scan

Interface
REQ-001 The block SHALL have parameter FIRST_CH, default 0, meaning the channel index (0..7) loaded into the round-robin pointer at reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have ports in1..in8, input, 1 bit each, channel data; channel k (0..7) is in(k+1).
REQ-005 The block SHALL have ports req1..req8, input, 1 bit each, level request from channel k.
REQ-006 The block SHALL have port out_ready, input, 1 bit, downstream accepts the word.
REQ-007 The block SHALL have port out_y, output, 1 bit, the registered data bit of the granted channel.
REQ-008 The block SHALL have ports outs1, outs2, outs3, output, 1 bit each, the registered channel index; outs1 is the MSB and outs3 the LSB, matching the select order of the 1x8 demultiplexer so that outs1..outs3 drive its ins1..ins3 directly.
REQ-009 The block SHALL have port out_valid, output, 1 bit, asserted when out_y and outs1..outs3 hold a word.
REQ-010 The block SHALL have ports ack1..ack8, output, 1 bit each, a one-cycle pulse to channel k after its word transfers.

Function
REQ-011 The block SHALL implement three states: IDLE, HOLD and ACK.
REQ-012 In IDLE with any req high, the block SHALL grant the first requesting channel found searching upward from the pointer, wrapping 7->0, and move to HOLD at the next edge.
REQ-013 At grant, the block SHALL register out_y = in(k+1) and outs1..outs3 = k.
REQ-014 Latency SHALL be one cycle: req sampled high at edge N gives out_valid=1 after edge N.
REQ-015 In IDLE with no req high, the block SHALL stay in IDLE with out_valid=0 and the pointer unchanged.
REQ-016 In HOLD, out_valid SHALL be 1, and out_y and outs1..outs3 SHALL stay stable regardless of in/req changes.
REQ-017 A transfer SHALL occur on any edge in HOLD where out_ready=1; this includes the first HOLD cycle.
REQ-018 On transfer, the block SHALL go to ACK, clear out_valid, set the pointer to (k+1) mod 8, and raise only ack(k+1) for exactly one cycle.
REQ-019 If out_ready=0 in HOLD, the block SHALL wait indefinitely in HOLD; there is no timeout.
REQ-020 If the granted channel drops req during HOLD, the block SHALL ignore it and still complete the transfer and ack.
REQ-021 From ACK, the block SHALL always return to IDLE at the next edge; no grant is made in ACK.
REQ-022 Peak throughput SHALL be one word per 3 cycles.
REQ-023 A requester SHALL drop req on the edge after it sees ack; the block does not filter a req held longer, which is re-served per round robin.
REQ-024 At most one ack line SHALL be high in any cycle.
REQ-025 ack SHALL never be high while out_valid is high.

Reset
REQ-026 rst=1 at an edge SHALL force the following: state IDLE, out_valid=0, out_y=0, outs1..outs3=0, ack1..ack8=0, pointer=FIRST_CH.
REQ-027 Reset SHALL take priority over all inputs.
REQ-028 rst asserted in HOLD SHALL abandon the pending word with no ack.
REQ-029 rst asserted in ACK SHALL clear the ack pulse on that edge.
REQ-030 The first grant SHALL be possible on the first edge with rst=0.

Verification
REQ-031 Bench SHALL check single request: reset, then req3=1, in3=1, out_ready=1. Required: next cycle out_valid=1, out_y=1, outs1..3=010; next cycle ack3=1, out_valid=0; then IDLE.
REQ-032 Bench SHALL check round robin: all req1..8=1 held, in(k+1)=k[0], out_ready=1, FIRST_CH=0. Required: outs sequence 000,001,...,111,000; each word 3 cycles apart; out_y alternates 0,1.
REQ-033 Bench SHALL check backpressure: grant channel 5 (outs=101, in6=1), out_ready=0 for 4 cycles while in6 toggles and req6 drops. Required: out_valid=1 and out_y=1 stable all 4 cycles; ack6 pulses once after out_ready=1.
REQ-034 Bench SHALL check wrap priority: pointer=7 after serving channel 6, then req1 and req8 both high. Required: channel 7 (outs=111) is granted first, then channel 0.
REQ-035 Bench SHALL check reset mid-operation: rst=1 during HOLD of channel 2. Required: next cycle all outputs 0 and no ack3. With FIRST_CH=0 and req1 and req3 high afterwards, channel 0 is granted first.
REQ-036 Bench SHALL check end to end: outs1..3 and out_y drive a 1x8 demultiplexer with data=out_y. Required: for each granted k, only demux output k+1 follows out_y.
